// File: rtl/tag_dispatcher.sv
// -----------------------------------------------------------------------------
// tag_dispatcher
//
// Initiator side of the double-buffer tag protocol. Hands out buffer tags
// round-robin to incoming tile requests (tag_req), re-runs compute on the most
// recently allocated tag (tag_reuse), closes it (tag_flush), and routes the
// ldmem / compute / stmem done pulses to whichever tag is currently active in
// each pipeline stage. Sits between the instruction decoder and the per-buffer
// tag FSMs.
//
// Build option:
//   TAG_DISPATCH_STATS_EN  when defined, adds saturating counters
//                          stat_alloc_cnt (accepted requests) and
//                          stat_stall_cnt (cycles with blk_req & ~blk_ready).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   blk_req/blk_reuse/blk_flush decoder commands
//   blk_bias_prev_sw, blk_ddr_pe_sw  switches broadcast with req/reuse pulses
//   blk_ready                  a request can be accepted this cycle
//   all_idle                   every tag done and dispatcher idle
//   tag_req/tag_reuse/tag_flush one-hot, single-cycle pulses to the tag FSMs
//   tag_bias_prev_sw, tag_ddr_pe_sw  registered broadcast switches
//   tag_ready, tag_done        per-tag status from the tag FSMs
//   *_tag_ready, next_compute_tag    per-tag stage status from the tag FSMs
//   ldmem_done/compute_done/stmem_done  stage completion pulses
//   *_tag_done                 completion pulses steered to the active tag
//   *_ready                    readiness of the active tag in each stage
//   ldmem_tag/compute_tag/stmem_tag  active tag index of each stage
// -----------------------------------------------------------------------------
module tag_dispatcher #(
    parameter int NUM_TAGS = 2,
    parameter int TAG_W    = $clog2(NUM_TAGS),
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                blk_req,
    input  logic                blk_reuse,
    input  logic                blk_flush,
    input  logic                blk_bias_prev_sw,
    input  logic                blk_ddr_pe_sw,
    output logic                blk_ready,
    output logic                all_idle,

    output logic [NUM_TAGS-1:0] tag_req,
    output logic [NUM_TAGS-1:0] tag_reuse,
    output logic [NUM_TAGS-1:0] tag_flush,
    output logic                tag_bias_prev_sw,
    output logic                tag_ddr_pe_sw,
    input  logic [NUM_TAGS-1:0] tag_ready,
    input  logic [NUM_TAGS-1:0] tag_done,

    input  logic [NUM_TAGS-1:0] ldmem_tag_ready,
    input  logic [NUM_TAGS-1:0] compute_tag_ready,
    input  logic [NUM_TAGS-1:0] stmem_tag_ready,
    input  logic [NUM_TAGS-1:0] next_compute_tag,

    input  logic                ldmem_done,
    input  logic                compute_done,
    input  logic                stmem_done,
    output logic [NUM_TAGS-1:0] ldmem_tag_done,
    output logic [NUM_TAGS-1:0] compute_tag_done,
    output logic [NUM_TAGS-1:0] stmem_tag_done,
    output logic                ldmem_ready,
    output logic                compute_ready,
    output logic                stmem_ready,
`ifdef TAG_DISPATCH_STATS_EN
    output logic [CNT_W-1:0]    stat_alloc_cnt,
    output logic [CNT_W-1:0]    stat_stall_cnt,
`endif
    output logic [TAG_W-1:0]    ldmem_tag,
    output logic [TAG_W-1:0]    compute_tag,
    output logic [TAG_W-1:0]    stmem_tag
);

    // Pointer arithmetic below wraps by plain overflow, so the tag count must
    // fill the index width exactly.
    if ((NUM_TAGS < 2) || ((NUM_TAGS & (NUM_TAGS - 1)) != 0) ||
        (TAG_W != $clog2(NUM_TAGS)) || (CNT_W < 1)) begin : g_bad_params
        $error("tag_dispatcher: NUM_TAGS must be a power of two >= 2, TAG_W = clog2(NUM_TAGS), CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DRAIN
    } state_t;

    localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);
    localparam logic [TAG_W-1:0] PTR_LAST = TAG_W'(NUM_TAGS - 1);

    state_t           state_q, state_d;

    logic [TAG_W-1:0] alloc_ptr;   // next tag to hand out
    logic [TAG_W-1:0] last_ptr;    // most recently allocated tag
    logic [TAG_W-1:0] ld_ptr;
    logic [TAG_W-1:0] cmp_ptr;
    logic [TAG_W-1:0] st_ptr;

    logic             accept;
    logic             reuse_fire;
    logic             flush_fire;
    logic             ld_fire;
    logic             cmp_fire;
    logic             st_fire;
    logic             cmp_advance;

    function automatic logic [NUM_TAGS-1:0] one_hot(input logic [TAG_W-1:0] idx);
        logic [NUM_TAGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // Command qualification
    // -------------------------------------------------------------------------
    assign blk_ready  = tag_ready[alloc_ptr] && (state_q != ST_DRAIN);
    assign accept     = blk_req && blk_ready;
    // A reuse that coincides with an accepted request is dropped: the new
    // request becomes the last allocated tag, so the reuse target is stale.
    assign reuse_fire = blk_reuse && !accept && (state_q != ST_IDLE);
    // A flush always targets the tag allocated before this cycle's request.
    assign flush_fire = blk_flush && (state_q != ST_IDLE);

    assign all_idle   = (&tag_done) && (state_q == ST_IDLE);

    // -------------------------------------------------------------------------
    // Stage steering. A done pulse for a tag that is not ready in that stage
    // is a protocol error: it is swallowed and the stage pointer holds.
    // -------------------------------------------------------------------------
    assign ld_fire     = ldmem_done   && ldmem_tag_ready[ld_ptr];
    assign cmp_fire    = compute_done && compute_tag_ready[cmp_ptr];
    assign st_fire     = stmem_done   && stmem_tag_ready[st_ptr];
    assign cmp_advance = next_compute_tag[cmp_ptr];

    assign ldmem_tag_done   = ld_fire  ? one_hot(ld_ptr)  : '0;
    assign compute_tag_done = cmp_fire ? one_hot(cmp_ptr) : '0;
    assign stmem_tag_done   = st_fire  ? one_hot(st_ptr)  : '0;

    assign ldmem_ready   = ldmem_tag_ready[ld_ptr];
    assign compute_ready = compute_tag_ready[cmp_ptr];
    assign stmem_ready   = stmem_tag_ready[st_ptr];

    assign ldmem_tag   = ld_ptr;
    assign compute_tag = cmp_ptr;
    assign stmem_tag   = st_ptr;

    // -------------------------------------------------------------------------
    // Dispatcher FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d
        // unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Closing the last tag with nothing left to load: wait for
                // every buffer to finish before accepting more work.
                if (flush_fire && (alloc_ptr == ld_ptr)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (&tag_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pointers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr <= '0;
            last_ptr  <= PTR_LAST;
            ld_ptr    <= '0;
            cmp_ptr   <= '0;
            st_ptr    <= '0;
        end else begin
            if (accept) begin
                alloc_ptr <= alloc_ptr + PTR_ONE;
                last_ptr  <= alloc_ptr;
            end
            if (ld_fire) begin
                ld_ptr <= ld_ptr + PTR_ONE;
            end
            if (cmp_advance) begin
                cmp_ptr <= cmp_ptr + PTR_ONE;
            end
            if (st_fire) begin
                st_ptr <= st_ptr + PTR_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered command pulses. Each is high for exactly the cycle after the
    // command was qualified; flush uses last_ptr before this cycle's update.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_req          <= '0;
            tag_reuse        <= '0;
            tag_flush        <= '0;
            tag_bias_prev_sw <= 1'b0;
            tag_ddr_pe_sw    <= 1'b0;
        end else begin
            tag_req   <= accept     ? one_hot(alloc_ptr) : '0;
            tag_reuse <= reuse_fire ? one_hot(last_ptr)  : '0;
            tag_flush <= flush_fire ? one_hot(last_ptr)  : '0;
            // Switches are captured alongside the pulse they qualify and then
            // held until the next req/reuse.
            if (accept || reuse_fire) begin
                tag_bias_prev_sw <= blk_bias_prev_sw;
                tag_ddr_pe_sw    <= blk_ddr_pe_sw;
            end
        end
    end

`ifdef TAG_DISPATCH_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating statistics counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_alloc_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (accept && (stat_alloc_cnt != '1)) begin
                stat_alloc_cnt <= stat_alloc_cnt + CNT_W'(1);
            end
            if (blk_req && !blk_ready && (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tag_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_tag_dispatcher
//
// Self-checking bench for tag_dispatcher (NUM_TAGS = 2). A reference model
// tracks how many tags have been allocated / loaded / computed / stored as
// plain counters (the active tag of each stage is the count modulo NUM_TAGS),
// plus the protocol phase. Every cycle all DUT outputs are compared with the
// model; directed scenarios add explicit constant expectations, then a long
// randomized run follows.
// -----------------------------------------------------------------------------
module tb_tag_dispatcher;

    localparam int N      = 2;
    localparam int TW     = 1;
    localparam int CW     = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_BUSY  = 1;
    localparam int P_DRAIN = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          blk_req, blk_reuse, blk_flush, blk_bias_prev_sw, blk_ddr_pe_sw;
    logic          blk_ready, all_idle;
    logic [N-1:0]  tag_req, tag_reuse, tag_flush;
    logic          tag_bias_prev_sw, tag_ddr_pe_sw;
    logic [N-1:0]  tag_ready, tag_done;
    logic [N-1:0]  ldmem_tag_ready, compute_tag_ready, stmem_tag_ready, next_compute_tag;
    logic          ldmem_done, compute_done, stmem_done;
    logic [N-1:0]  ldmem_tag_done, compute_tag_done, stmem_tag_done;
    logic          ldmem_ready, compute_ready, stmem_ready;
    logic [TW-1:0] ldmem_tag, compute_tag, stmem_tag;
`ifdef TAG_DISPATCH_STATS_EN
    logic [CW-1:0] stat_alloc_cnt, stat_stall_cnt;
`endif

    tag_dispatcher #(.NUM_TAGS(N), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .blk_req           (blk_req),
        .blk_reuse         (blk_reuse),
        .blk_flush         (blk_flush),
        .blk_bias_prev_sw  (blk_bias_prev_sw),
        .blk_ddr_pe_sw     (blk_ddr_pe_sw),
        .blk_ready         (blk_ready),
        .all_idle          (all_idle),
        .tag_req           (tag_req),
        .tag_reuse         (tag_reuse),
        .tag_flush         (tag_flush),
        .tag_bias_prev_sw  (tag_bias_prev_sw),
        .tag_ddr_pe_sw     (tag_ddr_pe_sw),
        .tag_ready         (tag_ready),
        .tag_done          (tag_done),
        .ldmem_tag_ready   (ldmem_tag_ready),
        .compute_tag_ready (compute_tag_ready),
        .stmem_tag_ready   (stmem_tag_ready),
        .next_compute_tag  (next_compute_tag),
        .ldmem_done        (ldmem_done),
        .compute_done      (compute_done),
        .stmem_done        (stmem_done),
        .ldmem_tag_done    (ldmem_tag_done),
        .compute_tag_done  (compute_tag_done),
        .stmem_tag_done    (stmem_tag_done),
        .ldmem_ready       (ldmem_ready),
        .compute_ready     (compute_ready),
        .stmem_ready       (stmem_ready),
`ifdef TAG_DISPATCH_STATS_EN
        .stat_alloc_cnt    (stat_alloc_cnt),
        .stat_stall_cnt    (stat_stall_cnt),
`endif
        .ldmem_tag         (ldmem_tag),
        .compute_tag       (compute_tag),
        .stmem_tag         (stmem_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit checks_on = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    int           m_alloc, m_load, m_comp, m_store;   // lifetime event counts
    int           m_last;
    int           m_phase;
    logic [N-1:0] m_req, m_reuse, m_flush;
    logic         m_bias, m_ddr;
    bit           m_sw_fresh;
    int           m_alloc_cnt, m_stall_cnt;

    function automatic logic [N-1:0] bit_of(input int i);
        return N'(1) << i;
    endfunction

    function automatic bit model_ready();
        return tag_ready[m_alloc % N] && (m_phase != P_DRAIN);
    endfunction

    task automatic model_reset();
        m_alloc = 0; m_load = 0; m_comp = 0; m_store = 0;
        m_last = N - 1;
        m_phase = P_IDLE;
        m_req = '0; m_reuse = '0; m_flush = '0;
        m_bias = 1'b0; m_ddr = 1'b0; m_sw_fresh = 1'b1;
        m_alloc_cnt = 0; m_stall_cnt = 0;
    endtask

    task automatic model_update();
        bit acc, reu, fl;
        int slot;
        if (reset) begin
            model_reset();
            return;
        end
        slot = m_alloc % N;
        acc  = blk_req && model_ready();
        reu  = blk_reuse && !acc && (m_phase != P_IDLE);
        fl   = blk_flush && (m_phase != P_IDLE);
        m_req   = acc ? bit_of(slot)   : '0;
        m_reuse = reu ? bit_of(m_last) : '0;
        m_flush = fl  ? bit_of(m_last) : '0;
        if (acc || reu) begin
            m_bias = blk_bias_prev_sw;
            m_ddr  = blk_ddr_pe_sw;
            m_sw_fresh = 1'b0;
        end
        if (blk_req && !model_ready() && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (acc && m_alloc_cnt < CNT_MAX) m_alloc_cnt++;
        case (m_phase)
            P_IDLE:  if (acc) m_phase = P_BUSY;
            P_BUSY:  if (fl && (slot == m_load % N)) m_phase = P_DRAIN;
            default: if (&tag_done) m_phase = P_IDLE;
        endcase
        if (acc) begin
            m_last = slot;
            m_alloc++;
        end
        if (ldmem_done && ldmem_tag_ready[m_load % N]) m_load++;
        if (next_compute_tag[m_comp % N]) m_comp++;
        if (stmem_done && stmem_tag_ready[m_store % N]) m_store++;
    endtask

    task automatic check_outputs();
        int lp, cp, sp;
        lp = m_load % N; cp = m_comp % N; sp = m_store % N;
        check("blk_ready",  blk_ready,  model_ready());
        check("all_idle",   all_idle,   (&tag_done) && (m_phase == P_IDLE));
        check("tag_req",    tag_req,    m_req);
        check("tag_reuse",  tag_reuse,  m_reuse);
        check("tag_flush",  tag_flush,  m_flush);
        if (m_sw_fresh || (m_req != '0) || (m_reuse != '0)) begin
            check("bias_sw", tag_bias_prev_sw, m_bias);
            check("ddr_sw",  tag_ddr_pe_sw,    m_ddr);
        end
        check("ldmem_tag",   ldmem_tag,   lp);
        check("compute_tag", compute_tag, cp);
        check("stmem_tag",   stmem_tag,   sp);
        check("ldmem_ready",   ldmem_ready,   ldmem_tag_ready[lp]);
        check("compute_ready", compute_ready, compute_tag_ready[cp]);
        check("stmem_ready",   stmem_ready,   stmem_tag_ready[sp]);
        check("ldmem_tag_done",   ldmem_tag_done,
              (ldmem_done && ldmem_tag_ready[lp]) ? bit_of(lp) : '0);
        check("compute_tag_done", compute_tag_done,
              (compute_done && compute_tag_ready[cp]) ? bit_of(cp) : '0);
        check("stmem_tag_done",   stmem_tag_done,
              (stmem_done && stmem_tag_ready[sp]) ? bit_of(sp) : '0);
`ifdef TAG_DISPATCH_STATS_EN
        check("stat_alloc", stat_alloc_cnt, m_alloc_cnt);
        check("stat_stall", stat_stall_cnt, m_stall_cnt);
`endif
    endtask

    // One clock cycle: inputs are already applied; compare, clock, update.
    task automatic step();
        #1;
        if (checks_on) check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_pulses();
        blk_req = 0; blk_reuse = 0; blk_flush = 0;
        blk_bias_prev_sw = 0; blk_ddr_pe_sw = 0;
        ldmem_done = 0; compute_done = 0; stmem_done = 0;
        next_compute_tag = '0; tag_done = '0;
    endtask

    task automatic do_reset();
        clear_pulses();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_pulses();
        tag_ready = 2'b11;
        ldmem_tag_ready = '0; compute_tag_ready = '0; stmem_tag_ready = '0;
        model_reset();
        step();
        step();
        reset = 1'b0;
        checks_on = 1'b1;

        // Reset state
        #1;
        check("rst_blk_ready", blk_ready, 1'b1);
        check("rst_ldmem_tag", ldmem_tag, 0);
        check("rst_tag_req",   tag_req, 2'b00);

        // Single request: one-cycle pulse on tag 0
        blk_req = 1;
        step();
        blk_req = 0;
        check("req_pulse", tag_req, 2'b01);
        step();
        check("req_pulse_end", tag_req, 2'b00);

        // Full: both tags taken, third request stalls until tag 0 frees
        do_reset();
        tag_ready = 2'b11;
        blk_req = 1;
        step();
        step();
        tag_ready = 2'b00;
        #1;
        check("full_not_ready", blk_ready, 1'b0);
        step();
        step();
        tag_ready = 2'b01;
        #1;
        check("free_ready", blk_ready, 1'b1);
        step();
        blk_req = 0;
        check("held_req_issued", tag_req, 2'b01);
        step();

        // ldmem steering from ld_ptr = 1, then wrap; error pulse swallowed
        do_reset();
        ldmem_tag_ready = 2'b01;
        ldmem_done = 1;
        step();
        ldmem_tag_ready = 2'b10;
        #1;
        check("ld_steer", ldmem_tag_done, 2'b10);
        step();
        ldmem_done = 0;
        check("ld_wrap", ldmem_tag, 0);
        ldmem_done = 1;
        #1;
        check("ld_err_nosteer", ldmem_tag_done, 2'b00);
        step();
        ldmem_done = 0;
        check("ld_err_hold", ldmem_tag, 0);

        // Reuse with bias switch, then req+reuse collision
        do_reset();
        tag_ready = 2'b11;
        blk_req = 1;
        step();
        blk_req = 0; blk_reuse = 1; blk_bias_prev_sw = 1;
        step();
        clear_pulses();
        check("reuse_pulse", tag_reuse, 2'b01);
        check("reuse_bias",  tag_bias_prev_sw, 1'b1);
        blk_req = 1; blk_reuse = 1;
        step();
        clear_pulses();
        check("collide_req",   tag_req, 2'b10);
        check("collide_reuse", tag_reuse, 2'b00);

        // Flush with nothing left to load -> drain -> idle
        do_reset();
        tag_ready = 2'b11;
        blk_req = 1; ldmem_tag_ready = 2'b01; ldmem_done = 1;
        step();
        clear_pulses();
        blk_flush = 1;
        step();
        clear_pulses();
        #1;
        check("drain_flush", tag_flush, 2'b01);
        check("drain_not_ready", blk_ready, 1'b0);
        tag_done = 2'b11;
        #1;
        check("drain_not_idle", all_idle, 1'b0);
        step();
        check("drain_to_idle", all_idle, 1'b1);
        tag_done = '0;

        // Reset while a request is presented: no pulse follows
        blk_req = 1; reset = 1;
        step();
        reset = 0; blk_req = 0;
        check("rst_no_pulse", tag_req, 2'b00);

`ifdef TAG_DISPATCH_STATS_EN
        do_reset();
        tag_ready = 2'b00;
        blk_req = 1;
        step(); step(); step();
        tag_ready = 2'b11;
        step(); step();
        blk_req = 0;
        check("stat_stall_3", stat_stall_cnt, 3);
        check("stat_alloc_2", stat_alloc_cnt, 2);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset            = ($urandom_range(0, 299) == 0);
            blk_req          = $urandom_range(0, 1);
            blk_reuse        = ($urandom_range(0, 3) == 0);
            blk_flush        = ($urandom_range(0, 7) == 0);
            blk_bias_prev_sw = $urandom_range(0, 1);
            blk_ddr_pe_sw    = $urandom_range(0, 1);
            tag_ready        = N'($urandom) | N'($urandom);
            tag_done         = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
            ldmem_tag_ready  = N'($urandom);
            compute_tag_ready = N'($urandom);
            stmem_tag_ready  = N'($urandom);
            next_compute_tag = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            ldmem_done       = $urandom_range(0, 1);
            compute_done     = $urandom_range(0, 1);
            stmem_done       = $urandom_range(0, 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
